// File: rtl/dmem_responder.sv
// Data-memory responder: posted-store write buffer drained into a word array, one-cycle loads.
// Define DMEM_FWD_EN to forward buffered store data to loads; otherwise matching loads stall.
module dmem_responder #(
  parameter int AW           = 10,
  parameter int WB_DEPTH     = 2,
  parameter int DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wr,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int PW   = $clog2(WB_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int CW   = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } state_t;

  logic [31:0]     r_mem     [2**AW];
  logic [AW-1:0]   r_wb_addr [WB_DEPTH];
  logic [31:0]     r_wb_data [WB_DEPTH];
  logic [PW-1:0]   r_head;
  logic [PW-1:0]   r_tail;
  logic [CNTW-1:0] r_count;
  state_t          r_state;
  logic [CW-1:0]   r_dcnt;
  logic            r_busy;
  logic            r_rsp_valid;
  logic [31:0]     r_rsp_rdata;
  logic            r_rsp_err;

  state_t          w_state_nxt;
  logic [CW-1:0]   w_dcnt_nxt;
  logic [CNTW-1:0] w_count_nxt;
  logic [WB_DEPTH-1:0] w_match;
  logic [31:0]     w_fwd_data;
  logic [31:0]     w_ld_data;
  logic            w_hit;
  logic            w_oor;
  logic            w_full;
  logic            w_hazard;
  logic            w_acc;
  logic            w_ld;
  logic            w_push;
  logic            w_pop;

  assign w_oor  = |req_addr[31:AW];
  assign w_full = (r_count == CNTW'(WB_DEPTH));

  // Address match against every occupied buffer slot, indexed by age from the head
  always_comb begin
    w_match = '0;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_match[k] = (CNTW'(k) < r_count) &&
                   (r_wb_addr[r_head + PW'(k)] == req_addr[AW-1:0]) && !w_oor;
    end
  end

  // Youngest matching entry wins, so later slots override earlier ones
  always_comb begin
    w_fwd_data = 32'h0000_0000;
    for (int k = 0; k < WB_DEPTH; k++) begin
      w_fwd_data = w_match[k] ? r_wb_data[r_head + PW'(k)] : w_fwd_data;
    end
  end

  assign w_hit = |w_match;

  // Hazard and load-data selection depend on whether forwarding is built in
  always_comb begin
`ifdef DMEM_FWD_EN
    w_hazard  = 1'b0;
    w_ld_data = w_hit ? w_fwd_data : r_mem[req_addr[AW-1:0]];
`else
    w_hazard  = w_hit;
    w_ld_data = r_mem[req_addr[AW-1:0]];
`endif
    if (w_oor) begin
      w_ld_data = 32'h0000_0000;
    end else begin
      w_ld_data = w_ld_data;
    end
  end

  assign req_ready = !rst && (req_wr ? !w_full : ((r_state == S_IDLE) && !w_hazard));
  assign w_acc     = req_valid && req_ready;
  assign w_ld      = w_acc && !req_wr;
  assign w_push    = w_acc && req_wr && !w_oor;

  // Drain FSM next state: an accepted load holds off the drain start
  always_comb begin
    w_state_nxt = r_state;
    w_dcnt_nxt  = r_dcnt;
    w_pop       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if ((r_count != CNTW'(0)) && !w_ld) begin
          w_state_nxt = S_BUSY;
          w_dcnt_nxt  = CW'(DRAIN_CYCLES);
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_BUSY: begin
        if (r_dcnt == CW'(1)) begin
          w_state_nxt = S_IDLE;
          w_dcnt_nxt  = CW'(0);
          w_pop       = 1'b1;
        end else begin
          w_dcnt_nxt  = r_dcnt - CW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_dcnt_nxt  = CW'(0);
      end
    endcase
  end

  // Occupancy bookkeeping for simultaneous push and pop
  always_comb begin
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNTW'(1);
      2'b01:   w_count_nxt = r_count - CNTW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Control state, pointers and registered responses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_dcnt      <= CW'(0);
      r_head      <= PW'(0);
      r_tail      <= PW'(0);
      r_count     <= CNTW'(0);
      r_busy      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'h0000_0000;
      r_rsp_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_dcnt      <= w_dcnt_nxt;
      r_count     <= w_count_nxt;
      r_busy      <= (w_count_nxt != CNTW'(0));
      r_head      <= w_pop  ? r_head + PW'(1) : r_head;
      r_tail      <= w_push ? r_tail + PW'(1) : r_tail;
      r_rsp_valid <= w_ld;
      r_rsp_err   <= w_acc && w_oor;
      r_rsp_rdata <= w_ld ? w_ld_data : r_rsp_rdata;
    end
  end

  // Buffer slots and the word array carry no reset; a commit during reset is dropped
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_wb_addr[r_tail] <= req_addr[AW-1:0];
      r_wb_data[r_tail] <= req_wdata;
    end
    if (!rst && w_pop) begin
      r_mem[r_wb_addr[r_head]] <= r_wb_data[r_head];
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;
  assign busy      = r_busy;

endmodule
